// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encoding for the CDB arbiter and its holding slots.
package cdb_arbiter_pkg;
    localparam int ROB_LEN  = 5;
    localparam int DATA_LEN = 32;
    localparam int ADDR_LEN = 32;

    localparam logic CDB_ALU = 1'b0;
    localparam logic CDB_LSB = 1'b1;
endpackage

// File: rtl/cdb_slot.sv
// One-entry holding slot: full flag plus payload, with load/drain/flush controls.
module cdb_slot
    import cdb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic                i_drain,
    input  logic                i_flush,
    input  logic [ROB_LEN-1:0]  i_robpos,
    input  logic [DATA_LEN-1:0] i_val,
    input  logic                i_isjump,
    input  logic [ADDR_LEN-1:0] i_jumpto,
    output logic                o_full,
    output logic [ROB_LEN-1:0]  o_robpos,
    output logic [DATA_LEN-1:0] o_val,
    output logic                o_isjump,
    output logic [ADDR_LEN-1:0] o_jumpto
);
    logic                r_full;
    logic [ROB_LEN-1:0]  r_robpos;
    logic [DATA_LEN-1:0] r_val;
    logic                r_isjump;
    logic [ADDR_LEN-1:0] r_jumpto;

    // Load wins over drain so a drain/reload edge keeps the slot full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full   <= 1'b0;
            r_robpos <= '0;
            r_val    <= '0;
            r_isjump <= 1'b0;
            r_jumpto <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full   <= 1'b1;
            r_robpos <= i_robpos;
            r_val    <= i_val;
            r_isjump <= i_isjump;
            r_jumpto <= i_jumpto;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full   = r_full;
    assign o_robpos = r_robpos;
    assign o_val    = r_val;
    assign o_isjump = r_isjump;
    assign o_jumpto = r_jumpto;
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin sharing of the registered CDB between the ALU and the LSB,
// one result per cycle, flushed by clear and frozen while ready is low.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                clear,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ROB_LEN-1:0]  alu_robpos,
    input  logic [DATA_LEN-1:0] alu_val,
    input  logic                alu_isjump,
    input  logic [ADDR_LEN-1:0] alu_jumpto,
    input  logic                lsb_valid,
    output logic                lsb_ready,
    input  logic [ROB_LEN-1:0]  lsb_robpos,
    input  logic [DATA_LEN-1:0] lsb_val,
    output logic                cdb_flag,
    output logic                cdb_src,
    output logic [ROB_LEN-1:0]  cdb_robpos,
    output logic [DATA_LEN-1:0] cdb_val,
    output logic                cdb_isjump,
    output logic [ADDR_LEN-1:0] cdb_jumpto
);
    logic                w_alu_full, w_lsb_full;
    logic [ROB_LEN-1:0]  w_alu_robpos, w_lsb_robpos;
    logic [DATA_LEN-1:0] w_alu_val, w_lsb_val;
    logic                w_alu_isjump, w_lsb_isjump;
    logic [ADDR_LEN-1:0] w_alu_jumpto, w_lsb_jumpto;
    logic                w_grant_alu, w_grant_lsb, w_advance, w_flush;

    logic                r_last;
    logic                r_cdb_flag, r_cdb_src, r_cdb_isjump;
    logic [ROB_LEN-1:0]  r_cdb_robpos;
    logic [DATA_LEN-1:0] r_cdb_val;
    logic [ADDR_LEN-1:0] r_cdb_jumpto;

    assign w_grant_alu = w_alu_full && (!w_lsb_full || r_last == CDB_LSB);
    assign w_grant_lsb = w_lsb_full && (!w_alu_full || r_last == CDB_ALU);
    assign w_advance   = ready && !clear;
    assign w_flush     = ready && clear;

    // Readiness never looks at x_valid, so no valid-to-CDB combinational path.
    assign alu_ready = reset && w_advance && (!w_alu_full || w_grant_alu);
    assign lsb_ready = reset && w_advance && (!w_lsb_full || w_grant_lsb);

    cdb_slot u_alu_slot (
        .clk(clk), .reset(reset),
        .i_load(alu_valid && alu_ready), .i_drain(w_advance && w_grant_alu), .i_flush(w_flush),
        .i_robpos(alu_robpos), .i_val(alu_val), .i_isjump(alu_isjump), .i_jumpto(alu_jumpto),
        .o_full(w_alu_full), .o_robpos(w_alu_robpos), .o_val(w_alu_val),
        .o_isjump(w_alu_isjump), .o_jumpto(w_alu_jumpto)
    );

    cdb_slot u_lsb_slot (
        .clk(clk), .reset(reset),
        .i_load(lsb_valid && lsb_ready), .i_drain(w_advance && w_grant_lsb), .i_flush(w_flush),
        .i_robpos(lsb_robpos), .i_val(lsb_val), .i_isjump(1'b0), .i_jumpto('0),
        .o_full(w_lsb_full), .o_robpos(w_lsb_robpos), .o_val(w_lsb_val),
        .o_isjump(w_lsb_isjump), .o_jumpto(w_lsb_jumpto)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last       <= CDB_LSB;
            r_cdb_flag   <= 1'b0;
            r_cdb_src    <= 1'b0;
            r_cdb_robpos <= '0;
            r_cdb_val    <= '0;
            r_cdb_isjump <= 1'b0;
            r_cdb_jumpto <= '0;
        end else if (!ready) begin
            r_cdb_flag <= 1'b0;
        end else if (clear) begin
            r_cdb_flag <= 1'b0;
            r_last     <= CDB_LSB;
        end else if (w_grant_alu) begin
            r_cdb_flag   <= 1'b1;
            r_cdb_src    <= CDB_ALU;
            r_cdb_robpos <= w_alu_robpos;
            r_cdb_val    <= w_alu_val;
            r_cdb_isjump <= w_alu_isjump;
            r_cdb_jumpto <= w_alu_jumpto;
            r_last       <= CDB_ALU;
        end else if (w_grant_lsb) begin
            r_cdb_flag   <= 1'b1;
            r_cdb_src    <= CDB_LSB;
            r_cdb_robpos <= w_lsb_robpos;
            r_cdb_val    <= w_lsb_val;
            r_cdb_isjump <= w_lsb_isjump;
            r_cdb_jumpto <= w_lsb_jumpto;
            r_last       <= CDB_LSB;
        end else begin
            r_cdb_flag <= 1'b0;
        end
    end

    assign cdb_flag   = r_cdb_flag;
    assign cdb_src    = r_cdb_src;
    assign cdb_robpos = r_cdb_robpos;
    assign cdb_val    = r_cdb_val;
    assign cdb_isjump = r_cdb_isjump;
    assign cdb_jumpto = r_cdb_jumpto;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single writeback/broadcast bus (CDB) between the ALU and the load-store buffer. Each source gets a one-entry holding slot and a valid/ready handshake; a round-robin arbiter moves at most one result per cycle onto a registered CDB. The CDB feeds the reorder buffer's `alu_*` update port and the reservation-station and LSB snoop inputs. The arbiter flushes on `clear` and freezes when `ready` is low.

## Interface
- No parameters. Widths come from `ROB_LEN`, `DATA_LEN` and `ADDR_LEN` in `def.v`.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low. 0 asserts reset.
- `ready` in 1: global advance enable.
- `clear` in 1: mispredict flush from the reorder buffer.
- `alu_valid` in 1: ALU offers a result this cycle.
- `alu_ready` out 1: ALU offer is accepted this cycle.
- `alu_robpos` in ROB_LEN, `alu_val` in DATA_LEN, `alu_isjump` in 1, `alu_jumpto` in ADDR_LEN: ALU payload.
- `lsb_valid` in 1: LSB offers a load result this cycle.
- `lsb_ready` out 1: LSB offer is accepted this cycle.
- `lsb_robpos` in ROB_LEN, `lsb_val` in DATA_LEN: LSB payload.
- `cdb_flag` out 1: registered one-cycle broadcast strobe.
- `cdb_src` out 1: source of the current broadcast. 0 = ALU, 1 = LSB.
- `cdb_robpos` out ROB_LEN, `cdb_val` out DATA_LEN, `cdb_isjump` out 1, `cdb_jumpto` out ADDR_LEN: broadcast payload.

## Operation
**Slot state (per source)**
- Each source has one slot: `full` plus the payload.
- For the LSB slot, isjump and jumpto are stored as 0.

**Source handshake**
- `x_ready = reset && ready && !clear && (!full_x || grant_x)`. This is combinational.
- A transfer happens on a rising edge where `x_valid && x_ready`; the payload loads into the slot.
- Transfer and drain in the same cycle: the slot is reloaded and stays full.

**Arbitration**
- `grant_alu = full_alu && (!full_lsb || last == 1)`.
- `grant_lsb = full_lsb && (!full_alu || last == 0)`.
- At most one grant is asserted per cycle.

**On an edge with `ready && !clear`**
- If a grant is asserted:
  - `cdb_flag <= 1`.
  - The payload and `cdb_src` take the granted slot's contents.
  - The granted slot clears, unless it is reloaded that edge.
  - `last <= granted source`.
- With no grant, `cdb_flag <= 0` and the payload holds.

**`clear` (ready high)**
- Both slots empty.
- `cdb_flag <= 0`.
- `last <= 1`.
- No source accepts.
- A result in flight on the CDB during the `clear` cycle is still presented that cycle. The reorder buffer discards it.

**`ready` low**
- `cdb_flag <= 0`.
- Slots, payload and `last` hold.
- Both `x_ready` are 0.
- Grants are not acted on.

**`reset` asserted (async)**
- Slots empty, `last = 1`.
- `cdb_flag`, `cdb_src`, `cdb_robpos`, `cdb_val`, `cdb_isjump`, `cdb_jumpto` all 0.
- `alu_ready = lsb_ready = 0` while reset is low.
- Reset mid-transfer drops every held result.

## Timing
- Latency: a result accepted at edge N into an empty slot, with no competitor, is driven with `cdb_flag = 1` during the cycle after edge N+1.
- There is no combinational path from `x_valid` to `cdb_*`.
- Throughput: one broadcast per cycle total.
- A single source streaming alone sustains one result per cycle, because of drain/reload in the same cycle.
- Contention: both slots full gives alternating grants, so the worst-case wait is one cycle.
- Tie out of reset or flush: the ALU wins first.
- `cdb_flag` is high for exactly one cycle per granted result. It never repeats a slot's contents.
- `x_ready` depends on `full`, `last`, `ready` and `clear` only. It does not depend on `x_valid`.

## Structure
- Source encoding goes in `def.v`: `CDB_ALU` = 0, `CDB_LSB` = 1.
- All width macros are reused from `def.v`.
- One sub-module, `cdb_slot`: the full flag plus payload registers, with load/drain/flush inputs. It is instantiated twice. Arbitration and the output register live in `cdb_arbiter`.

## Test plan
- **Reset:** hold `reset = 0` with `alu_valid = 1`. Required: `alu_ready = 0`, `cdb_flag = 0`, all payload outputs 0. Release reset; the ALU offer of robpos 3 / val 0x11 is broadcast two edges later with `cdb_src = 0`.
- **Contention:** ALU and LSB valid every cycle; ALU robpos 1, 2, …; LSB robpos 9, 10, …. Required CDB order: 1, 9, 2, 10, …, with exactly one `cdb_flag` per cycle and no duplicates or drops.
- **Streaming:** ALU alone valid for 8 cycles. Required: `alu_ready` stays 1 throughout, and 8 consecutive `cdb_flag` cycles carry the robpos values in order.
- **Stall:** both slots full, then `ready = 0` for 3 cycles. Required: `cdb_flag = 0` and `x_ready = 0` during the stall, slots preserved. After `ready` returns, both results appear on consecutive cycles.
- **Flush:** both slots full, `clear = 1` for one cycle. Required: next cycle `cdb_flag = 0`, slots empty. A later simultaneous offer is granted to the ALU first.
- **Jump payload:** ALU offer with isjump = 1, jumpto = 0x104. Required: `cdb_isjump = 1`, `cdb_jumpto = 0x104`. A following LSB broadcast shows isjump = 0 and jumpto = 0.
